bcd_acc: RTL and testbench

- Downstream consumer of the x5 BCD multiplier stage.
- Takes each two-digit BCD product (tens d, units u) and adds it to a running NDIG-digit packed-BCD total.
- Addition is digit-serial: one BCD digit per clock, driven by a small FSM with a valid/ready handshake.
- Feeds the lab display/readout logic with the accumulated total, an overflow flag and an error flag.

---
 rtl/bcd_acc.sv | 170 +++++++++++++++++
 tb/tb_bcd_acc.sv | 254 +++++++++++++++++++++++++
 2 files changed

// File: rtl/bcd_acc.sv
`default_nettype none
// ============================================================================
// Module   : bcd_acc
// Purpose  : Digit-serial packed-BCD accumulator. Each accepted two-digit BCD
//            operand (tens d, units u) is added to an NDIG-digit running total,
//            one BCD digit per clock, under a valid/ready handshake.
// Ports    : clk       - rising-edge clock
//            rst_n     - asynchronous active-low reset
//            in_valid  - operand (d,u) presented
//            in_ready  - operand can be accepted (IDLE and not clearing)
//            d, u      - operand tens / units digits, BCD
//            clr       - synchronous clear of total and flags
//            acc       - running total, packed BCD, digit 0 in bits [3:0]
//            out_valid - one-cycle pulse, operation finished, acc updated
//            ovf       - sticky overflow flag
//            err       - one-cycle pulse with out_valid, operand was not BCD
// Options  : BCD_ACC_SATURATE_EN - when defined, overflow forces acc to all-9s
//            instead of wrapping modulo 10^NDIG.
// Revision : 1.0 - initial release
// ============================================================================
module bcd_acc #(
    parameter int NDIG = 3
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [3:0]        d,
    input  logic [3:0]        u,
    input  logic              clr,
    output logic [4*NDIG-1:0] acc,
    output logic              out_valid,
    output logic              ovf,
    output logic              err
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_ADD  = 2'd1,
        S_DONE = 2'd2
    } state_t;

    // Digit index width covers NDIG up to 8.
    localparam int c_KW = 3;
`ifdef BCD_ACC_SATURATE_EN
    localparam logic [4*NDIG-1:0] c_NINES = {NDIG{4'h9}};
`endif

    state_t              r_state;
    state_t              w_next;
    logic [4*NDIG-1:0]   r_acc;
    logic [7:0]          r_opd;
    logic                r_carry;
    logic [c_KW-1:0]     r_k;
    logic                r_err_pend;
    logic                r_ovf;
    logic                r_out_valid;
    logic                r_err;

    logic                w_accept;
    logic                w_opd_bad;
    logic                w_last;
    logic [3:0]          w_opd_dig;
    logic [3:0]          w_acc_dig;
    logic [4:0]          w_sum;
    logic                w_gt9;
    logic [3:0]          w_new_dig;

    assign in_ready  = (r_state == S_IDLE) && !clr;
    assign w_accept  = in_valid && in_ready;
    assign w_opd_bad = (d > 4'd9) || (u > 4'd9);
    assign w_last    = (r_k == c_KW'(NDIG - 1));

    // Operand digits above the tens position are implicitly zero.
    always_comb begin
        w_opd_dig = 4'd0;
        if (r_k == c_KW'(0))
            w_opd_dig = r_opd[3:0];
        else if (r_k == c_KW'(1))
            w_opd_dig = r_opd[7:4];
    end

    assign w_acc_dig = r_acc[{r_k, 2'b00} +: 4];
    assign w_sum     = {1'b0, w_acc_dig} + {1'b0, w_opd_dig} + {4'd0, r_carry};
    assign w_gt9     = (w_sum > 5'd9);
    // s-10 modulo 16 equals s+6 modulo 16, so the decimal-adjust stays 4 bits.
    assign w_new_dig = w_gt9 ? (w_sum[3:0] + 4'd6) : w_sum[3:0];

    // Next-state logic
    always_comb begin
        w_next = r_state;
        case (r_state)
            S_IDLE: if (w_accept) w_next = w_opd_bad ? S_DONE : S_ADD;
            S_ADD:  if (w_last)   w_next = S_DONE;
            S_DONE: w_next = S_IDLE;
            default: w_next = S_IDLE;
        endcase
        if (clr)
            w_next = S_IDLE;
    end

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            r_state <= S_IDLE;
        else
            r_state <= w_next;
    end

    // Datapath and output registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_acc       <= '0;
            r_opd       <= '0;
            r_carry     <= 1'b0;
            r_k         <= '0;
            r_err_pend  <= 1'b0;
            r_ovf       <= 1'b0;
            r_out_valid <= 1'b0;
            r_err       <= 1'b0;
        end else if (clr) begin
            // Aborts any operation in flight without reporting it.
            r_acc       <= '0;
            r_opd       <= '0;
            r_carry     <= 1'b0;
            r_k         <= '0;
            r_err_pend  <= 1'b0;
            r_ovf       <= 1'b0;
            r_out_valid <= 1'b0;
            r_err       <= 1'b0;
        end else begin
            r_out_valid <= 1'b0;
            r_err       <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (w_accept) begin
                        r_opd      <= {d, u};
                        r_carry    <= 1'b0;
                        r_k        <= '0;
                        r_err_pend <= w_opd_bad;
                    end
                end
                S_ADD: begin
                    r_acc[{r_k, 2'b00} +: 4] <= w_new_dig;
                    r_carry                  <= w_gt9;
                    r_k                      <= r_k + c_KW'(1);
                end
                S_DONE: begin
                    r_out_valid <= 1'b1;
                    r_err       <= r_err_pend;
                    // Carry is always clear for a rejected operand.
                    if (r_carry) begin
                        r_ovf <= 1'b1;
`ifdef BCD_ACC_SATURATE_EN
                        r_acc <= c_NINES;
`endif
                    end
                end
                default: ;
            endcase
        end
    end

    assign acc       = r_acc;
    assign out_valid = r_out_valid;
    assign ovf       = r_ovf;
    assign err       = r_err;

endmodule
`default_nettype wire

// File: tb/tb_bcd_acc.sv
`default_nettype none
// ============================================================================
// Module   : tb_bcd_acc
// Purpose  : Self-checking bench for bcd_acc. A reference model computes the
//            expected total for each accepted operand and queues it; a monitor
//            pops and compares whenever out_valid pulses.
// Revision : 1.0 - initial release
// ============================================================================
module tb_bcd_acc;

    localparam int NDIG = 3;
    localparam int MOD  = 1000;

    logic              clk = 1'b0;
    logic              rst_n;
    logic              in_valid;
    logic              in_ready;
    logic [3:0]        d;
    logic [3:0]        u;
    logic              clr;
    logic [4*NDIG-1:0] acc;
    logic              out_valid;
    logic              ovf;
    logic              err;

    typedef struct packed {
        logic [4*NDIG-1:0] acc;
        logic              ovf;
        logic              err;
    } exp_t;

    exp_t q[$];
    exp_t e_mon;
    int   total = 0;
    int   bad   = 0;
    int   m_tot = 0;
    bit   m_ovf = 1'b0;

    bcd_acc #(.NDIG(NDIG)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .d         (d),
        .u         (u),
        .clr       (clr),
        .acc       (acc),
        .out_valid (out_valid),
        .ovf       (ovf),
        .err       (err)
    );

    always #5 clk = ~clk;

    function automatic logic [4*NDIG-1:0] to_bcd(input int v);
        logic [4*NDIG-1:0] r;
        int t;
        t = v;
        r = '0;
        for (int i = 0; i < NDIG; i++) begin
            r[4*i +: 4] = 4'(t % 10);
            t = t / 10;
        end
        return r;
    endfunction

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] expv);
        total++;
        assert (got === expv) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, got, expv);
        end
    endtask

    task automatic model_add(input logic [3:0] dd, input logic [3:0] uu);
        exp_t e;
        if (dd > 4'd9 || uu > 4'd9) begin
            e = '{acc: to_bcd(m_tot), ovf: m_ovf, err: 1'b1};
        end else begin
            m_tot = m_tot + 10 * int'(dd) + int'(uu);
            if (m_tot >= MOD) begin
                m_ovf = 1'b1;
`ifdef BCD_ACC_SATURATE_EN
                m_tot = MOD - 1;
`else
                m_tot = m_tot - MOD;
`endif
            end
            e = '{acc: to_bcd(m_tot), ovf: m_ovf, err: 1'b0};
        end
        q.push_back(e);
    endtask

    task automatic model_clear();
        m_tot = 0;
        m_ovf = 1'b0;
        q.delete();
    endtask

    // Handshake one operand and check the accept-to-out_valid latency.
    task automatic do_op(input logic [3:0] dd, input logic [3:0] uu);
        int n;
        int lat;
        int exp_lat;
        n = 0;
        @(negedge clk);
        while (!in_ready && n < 20) begin
            @(negedge clk);
            n++;
        end
        chk("in_ready_wait", {31'd0, in_ready}, 32'd1);
        in_valid = 1'b1;
        d        = dd;
        u        = uu;
        model_add(dd, uu);
        @(posedge clk);
        #1 in_valid = 1'b0;
        lat = 0;
        do begin
            @(posedge clk);
            lat++;
            #1;
        end while (!out_valid && lat < 20);
        exp_lat = (dd > 4'd9 || uu > 4'd9) ? 1 : NDIG + 1;
        chk("latency", lat, exp_lat);
    endtask

    // Scoreboard monitor
    always @(negedge clk) begin
        if (rst_n) begin
            if (out_valid) begin
                if (q.size() == 0) begin
                    chk("stray_out_valid", {31'd0, out_valid}, 32'd0);
                end else begin
                    e_mon = q.pop_front();
                    chk("acc", {20'd0, acc}, {20'd0, e_mon.acc});
                    chk("ovf", {31'd0, ovf}, {31'd0, e_mon.ovf});
                    chk("err", {31'd0, err}, {31'd0, e_mon.err});
                end
            end else begin
                chk("err_without_valid", {31'd0, err}, 32'd0);
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog timeout total=%0d bad=%0d", total, bad);
        $fatal(1, "watchdog");
    end

    initial begin
        rst_n    = 1'b0;
        clr      = 1'b0;
        in_valid = 1'b0;
        d        = 4'd0;
        u        = 4'd0;
        #23;
        chk("rst_acc", {20'd0, acc}, 32'd0);
        chk("rst_out_valid", {31'd0, out_valid}, 32'd0);
        chk("rst_ovf", {31'd0, ovf}, 32'd0);
        chk("rst_err", {31'd0, err}, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        #1 chk("rst_in_ready", {31'd0, in_ready}, 32'd1);

        // 045, 090 (ripple into tens), 100 (ripple into hundreds)
        do_op(4'd4, 4'd5);
        do_op(4'd4, 4'd5);
        do_op(4'd1, 4'd0);

        // Clear, accumulate to 995, then overflow
        @(negedge clk);
        clr = 1'b1;
        @(negedge clk);
        clr = 1'b0;
        model_clear();
        #1 chk("clr_acc", {20'd0, acc}, 32'd0);
        repeat (22) do_op(4'd4, 4'd5);
        do_op(4'd0, 4'd5);
        do_op(4'd1, 4'd0);
        do_op(4'd0, 4'd5);

        // Invalid operand, then a valid one
        do_op(4'd0, 4'd12);
        do_op(4'd3, 4'd5);

        // clr mid-ADD aborts the operation in flight
        @(negedge clk);
        in_valid = 1'b1;
        d        = 4'd4;
        u        = 4'd5;
        @(posedge clk);
        #1 in_valid = 1'b0;
        @(negedge clk);
        clr = 1'b1;
        @(posedge clk);
        #1;
        chk("midclr_acc", {20'd0, acc}, 32'd0);
        chk("midclr_ovf", {31'd0, ovf}, 32'd0);
        @(negedge clk);
        clr = 1'b0;
        model_clear();
        repeat (8) @(negedge clk);
        chk("midclr_idle_acc", {20'd0, acc}, 32'd0);

        // clr in the same cycle as in_valid: operand refused
        clr      = 1'b1;
        in_valid = 1'b1;
        d        = 4'd4;
        u        = 4'd5;
        #1 chk("clr_blocks_ready", {31'd0, in_ready}, 32'd0);
        @(posedge clk);
        #1 in_valid = 1'b0;
        @(negedge clk);
        clr = 1'b0;
        #1 chk("clr_still_idle", {31'd0, in_ready}, 32'd1);
        repeat (6) @(posedge clk);
        #1 chk("clr_not_added", {20'd0, acc}, 32'd0);

        // Asynchronous reset mid-operation
        @(negedge clk);
        in_valid = 1'b1;
        d        = 4'd4;
        u        = 4'd5;
        @(posedge clk);
        #1 in_valid = 1'b0;
        @(posedge clk);
        #3 rst_n = 1'b0;
        #1;
        chk("arst_acc", {20'd0, acc}, 32'd0);
        chk("arst_out_valid", {31'd0, out_valid}, 32'd0);
        chk("arst_ovf", {31'd0, ovf}, 32'd0);
        chk("arst_err", {31'd0, err}, 32'd0);
        model_clear();
        @(negedge clk);
        rst_n = 1'b1;
        #1 chk("arst_in_ready", {31'd0, in_ready}, 32'd1);

        // Multiplier products 05..45 sum to 225
        for (int i = 1; i <= 9; i++) begin
            do_op(4'((5 * i) / 10), 4'((5 * i) % 10));
        end
        @(negedge clk);
        chk("sum_225", {20'd0, acc}, {20'd0, to_bcd(225)});

        repeat (3) @(negedge clk);
        chk("scoreboard_drained", q.size(), 32'd0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire
